// File: rtl/uart_tx_fifo_transmitter_pkg.sv
// Shared constants for the UART transmit path: FSM state encodings, data width and the
// cycles-per-bit formula (the receiver derives its bit timing from the same function).
package uart_tx_fifo_transmitter_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_transmitter_if.sv
// Byte handshake from the datapath into the UART transmitter; a byte moves on an edge
// where DataInValid && DataInReady.
interface uart_tx_fifo_transmitter_if;
    import uart_tx_fifo_transmitter_pkg::*;

    logic [DATA_BITS-1:0] DataIn;
    logic                 DataInValid;
    logic                 DataInReady;

    modport master (output DataIn, output DataInValid, input DataInReady);
    modport slave  (input DataIn, input DataInValid, output DataInReady);

endinterface

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous register FIFO of bytes for the UART transmitter; full is a registered flag
// so that the upstream ready derived from it cannot glitch.
module uart_tx_byte_fifo
    import uart_tx_fifo_transmitter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           CLK,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_BITS-1:0]           din,
    input  logic                           pop,
    output logic [DATA_BITS-1:0]           dout,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(FIFO_DEPTH):0]    count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, full_d;

    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a variable unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CNT_W'(FIFO_DEPTH));
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
        end
    end

    // NOTE: storage is not reset; clearing the pointers and count already makes any stale entry unreachable.
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo_transmitter.sv
// FIFO-buffered UART transmitter producing start / 8 data LSB first / stop frames on SOut.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo_transmitter
    import uart_tx_fifo_transmitter_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                             CLK,
    input  logic                             reset,
    uart_tx_fifo_transmitter_if.slave        data_in,
    output logic                             SOut,
    output logic                             TxBusy
);

    localparam int SET   = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CYC_W = (SET > 1) ? $clog2(SET) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SET - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [CYC_W-1:0]     cyc_q, cyc_d;
    logic                 sout_q, sout_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;
    logic [CNT_W-1:0]     fifo_count;
    logic                 bit_end, load;

    assign data_in.DataInReady = ~fifo_full;
    assign fifo_push           = data_in.DataInValid & ~fifo_full;

    uart_tx_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (fifo_push),
        .din   (data_in.DataIn),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_end = (cyc_q == CYC_LAST);
    // A new frame starts from IDLE or directly at the end of a stop bit, so queued bytes leave with no idle gap.
    assign load = !fifo_empty && ((state_q == TX_IDLE) || (state_q == TX_STOP && bit_end));

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        cyc_d    = cyc_q;
        sout_d   = sout_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != TX_IDLE) cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);

        unique case (state_q)
            TX_IDLE: ;
            TX_START: begin
                if (bit_end) begin
                    state_d = TX_DATA;
                    sout_d  = shreg_q[0];
                    bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = TX_PARITY;
                        sout_d  = parity_q;
`else
                        state_d = TX_STOP;
                        sout_d  = 1'b1;
`endif
                    end else begin
                        shreg_d = {1'b0, shreg_q[DATA_BITS-1:1]};
                        sout_d  = shreg_q[1];
                        bit_d   = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: begin
                if (bit_end) begin
                    state_d = TX_STOP;
                    sout_d  = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (bit_end) begin
                    state_d = TX_IDLE;
                    sout_d  = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                sout_d  = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dout;
            state_d  = TX_START;
            sout_d   = 1'b0;
            cyc_d    = '0;
            bit_d    = '0;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout;
`endif
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q  <= TX_IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            cyc_q    <= '0;
            sout_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            cyc_q    <= cyc_d;
            sout_q   <= sout_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign SOut   = sout_q;
    assign TxBusy = (state_q != TX_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo_transmitter.sv
// Directed bench for uart_tx_fifo_transmitter at 10 cycles per bit and a 4-entry FIFO;
// honours UART_TX_PARITY_EN for the frame length and parity bit.
module tb_uart_tx_fifo_transmitter;

    localparam int CYC = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic CLK = 1'b0;
    logic reset;
    logic SOut, TxBusy;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_tx_fifo_transmitter_if dif ();

    uart_tx_fifo_transmitter #(
        .CLOCK_FREQ (1000),
        .BAUD_RATE  (100),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK     (CLK),
        .reset   (reset),
        .data_in (dif),
        .SOut    (SOut),
        .TxBusy  (TxBusy)
    );

    always #5 CLK = ~CLK;

    // Ready must only ever move at a rising clock edge (times 5, 15, 25, ...).
    bit mon_en = 1'b0;
    int rdy_changes = 0;
    int rdy_off_edge = 0;
    always @(dif.DataInReady) begin
        if (mon_en) begin
            rdy_changes++;
            if (($time % 10) != 5) rdy_off_edge++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push_byte(input logic [7:0] b, output int edges);
        logic r;
        dif.DataIn      = b;
        dif.DataInValid = 1'b1;
        edges = 0;
        do begin
            r = dif.DataInReady;
            @(negedge CLK);
            edges++;
        end while (!r && edges < 300);
        if (!r) check("push timeout", {31'd0, r}, 32'd1);
    endtask

    // Called at the falling edge of the first start-bit cycle; checks every cycle of every bit.
    task automatic check_frame(input logic [7:0] b, input logic par, input string tag);
        logic [FRAME_BITS-1:0] bits;
        int ok;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        bits[9] = par;
`endif
        bits[FRAME_BITS-1] = 1'b1;
        for (int k = 0; k < FRAME_BITS; k++) begin
            ok = 0;
            for (int c = 0; c < CYC; c++) begin
                if (SOut === bits[k]) ok++;
                @(negedge CLK);
            end
            check($sformatf("%s bit%0d", tag, k), ok, CYC);
        end
    endtask

    task automatic send_and_check(input logic [7:0] b, input logic par, input string tag);
        int w;
        push_byte(b, w);
        dif.DataInValid = 1'b0;
        check({tag, " accept"}, w, 1);
        check({tag, " sout before start"}, {31'd0, SOut}, 32'd1);
        check({tag, " busy while queued"}, {31'd0, TxBusy}, 32'd1);
        @(negedge CLK);
        check_frame(b, par, tag);
        check({tag, " busy after stop"}, {31'd0, TxBusy}, 32'd0);
        check({tag, " sout after stop"}, {31'd0, SOut}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (TxBusy && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(tag, {31'd0, TxBusy}, 32'd0);
    endtask

    logic [7:0] b2b [6] = '{8'h00, 8'hFF, 8'h55, 8'h0F, 8'hF0, 8'h3C};
    logic [7:0] fill [5] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};

    initial begin
        int w;
        int w_arr [6];
        int ok_s, ok_r, ok_b;

        reset           = 1'b1;
        dif.DataIn      = 8'h00;
        dif.DataInValid = 1'b0;

        // Reset idle
        repeat (3) @(negedge CLK);
        check("reset sout", {31'd0, SOut}, 32'd1);
        check("reset ready", {31'd0, dif.DataInReady}, 32'd1);
        check("reset busy", {31'd0, TxBusy}, 32'd0);
        reset = 1'b0;
        ok_s = 0; ok_r = 0; ok_b = 0;
        repeat (50) begin
            @(negedge CLK);
            if (SOut === 1'b1) ok_s++;
            if (dif.DataInReady === 1'b1) ok_r++;
            if (TxBusy === 1'b0) ok_b++;
        end
        check("idle sout high cycles", ok_s, 50);
        check("idle ready cycles", ok_r, 50);
        check("idle not busy cycles", ok_b, 50);

        // Single bytes, including the parity examples
        send_and_check(8'hA5, 1'b0, "A5");
        send_and_check(8'h07, 1'b1, "07");
        send_and_check(8'h03, 1'b0, "03");

        // Back-to-back: six bytes offered on consecutive cycles
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) push_byte(b2b[i], w_arr[i]);
                dif.DataInValid = 1'b0;
            end
            begin
                repeat (2) @(negedge CLK);
                for (int i = 0; i < 6; i++) check_frame(b2b[i], 1'b0, $sformatf("b2b%0d", i));
            end
        join
        for (int i = 0; i < 5; i++) check($sformatf("b2b%0d accept edges", i), w_arr[i], 1);
        // 0x3C waits through edges 6..102 and is taken on edge 103, one after 0xFF is popped.
        check("b2b5 accept edges", w_arr[5], 98);
        check("b2b busy after", {31'd0, TxBusy}, 32'd0);
        check("b2b sout after", {31'd0, SOut}, 32'd1);

        // Ready stability while full with Valid toggling
        for (int i = 0; i < 5; i++) begin
            push_byte(fill[i], w);
            check($sformatf("fill%0d accept", i), w, 1);
        end
        check("full ready low", {31'd0, dif.DataInReady}, 32'd0);
        rdy_changes = 0;
        dif.DataIn = 8'hEE;
        repeat (20) begin
            dif.DataInValid = ~dif.DataInValid;
            @(negedge CLK);
        end
        dif.DataInValid = 1'b0;
        check("ready toggles while full", rdy_changes, 0);
        check("ready still low", {31'd0, dif.DataInReady}, 32'd0);
        wait_idle("fill drain", 1000);
        check("ready off-edge changes", rdy_off_edge, 0);
        mon_en = 1'b0;

        // Reset during data bit 3 of 0xA5 with two bytes queued
        push_byte(8'hA5, w);
        push_byte(8'h11, w);
        push_byte(8'h22, w);
        dif.DataInValid = 1'b0;
        repeat (44) @(negedge CLK);
        check("pre-reset sout (A5 bit3)", {31'd0, SOut}, 32'd0);
        check("pre-reset busy", {31'd0, TxBusy}, 32'd1);
        reset = 1'b1;
        #1;
        check("async reset sout", {31'd0, SOut}, 32'd1);
        check("async reset ready", {31'd0, dif.DataInReady}, 32'd1);
        check("async reset busy", {31'd0, TxBusy}, 32'd0);
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        ok_s = 0; ok_b = 0;
        repeat (300) begin
            @(negedge CLK);
            if (SOut === 1'b1) ok_s++;
            if (TxBusy === 1'b0) ok_b++;
        end
        check("post-reset sout high cycles", ok_s, 300);
        check("post-reset not busy cycles", ok_b, 300);
        check("post-reset ready", {31'd0, dif.DataInReady}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
